// File: rtl/gf_collector_pkg.sv
// Shared constants and payload types for the greenfloat result collector.
package gf_collector_pkg;

   localparam int unsigned TAG_BITS = 4;
   localparam int unsigned TS_BITS  = 16;
   localparam int unsigned RES_BITS = 32;

   localparam logic       MODE_FP32 = 1'b0;
   localparam logic       MODE_FP16 = 1'b1;
   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_MUL    = 2'b10;

   typedef struct packed {
      logic [TAG_BITS-1:0] tag;
      logic                mode;
      logic [1:0]          op;
      logic [TS_BITS-1:0]  ts;
   } pend_t;

   typedef struct packed {
      logic [TAG_BITS-1:0] tag;
      logic                mode;
      logic [1:0]          op;
      logic [RES_BITS-1:0] result;
      logic                ovf;
      logic                unf;
      logic [TS_BITS-1:0]  latency;
   } rec_t;

endpackage

// File: rtl/gf_result_collector_if.sv
// Issue snoop, core result strobe and downstream record handshake bundle.
interface gf_result_collector_if #(
   parameter int unsigned TAG_W = 4,
   parameter int unsigned TS_W  = 16
);
   logic             iss_valid;
   logic             iss_mode;
   logic [1:0]       iss_op;
   logic [TAG_W-1:0] iss_tag;
   logic             iss_ready;

   logic             core_valid_out;
   logic [31:0]      core_result32;
   logic [15:0]      core_result16;
   logic             core_overflow;
   logic             core_underflow;

   logic             rec_valid;
   logic             rec_ready;
   logic [TAG_W-1:0] rec_tag;
   logic             rec_mode;
   logic [1:0]       rec_op;
   logic [31:0]      rec_result;
   logic             rec_ovf;
   logic             rec_unf;
   logic [TS_W-1:0]  rec_latency;

   modport master (
      output iss_valid, iss_mode, iss_op, iss_tag,
      input  iss_ready,
      output core_valid_out, core_result32, core_result16, core_overflow, core_underflow,
      input  rec_valid, rec_tag, rec_mode, rec_op, rec_result, rec_ovf, rec_unf, rec_latency,
      output rec_ready
   );

   modport slave (
      input  iss_valid, iss_mode, iss_op, iss_tag,
      output iss_ready,
      input  core_valid_out, core_result32, core_result16, core_overflow, core_underflow,
      output rec_valid, rec_tag, rec_mode, rec_op, rec_result, rec_ovf, rec_unf, rec_latency,
      input  rec_ready
   );
endinterface

// File: rtl/gf_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is visible combinationally on dout.
module gf_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/gf_result_collector.sv
// Pairs greenfloat_core results with snooped issues in FIFO order, buffers
// tagged records downstream, enforces issue credit and keeps statistics.
module gf_result_collector
   import gf_collector_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = TAG_BITS,
   parameter int unsigned TS_W  = TS_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   gf_result_collector_if.slave  bus,
   input  logic                  clear_stats,
   output logic [TS_W-1:0]       done_count,
   output logic [TS_W-1:0]       ovf_count,
   output logic [TS_W-1:0]       unf_count,
   output logic                  orphan_err,
   output logic                  overrun_err
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [TS_W-1:0] ts;
   pend_t           pend_in;
   pend_t           pend_head;
   rec_t            rec_in;
   rec_t            rec_head;
   logic [CW-1:0]   pend_count;
   logic [CW-1:0]   rec_count;
   logic            pend_empty;
   logic            pend_full;
   logic            rec_empty;
   logic            rec_full;
   logic [CW:0]     occupancy;
   logic            iss_fire;
   logic            res_fire;
   logic            orphan;
   logic            overrun;
   logic            rec_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts <= '0;
      else        ts <= ts + TS_W'(1);
   end

   // Credit covers both queues, so a matched result always finds record space.
   assign occupancy     = {1'b0, pend_count} + {1'b0, rec_count};
   assign bus.iss_ready = (occupancy < (CW+1)'(DEPTH));

   assign iss_fire = bus.iss_valid && bus.iss_ready;
   assign overrun  = bus.iss_valid && !bus.iss_ready;
   assign res_fire = bus.core_valid_out && !pend_empty;
   assign orphan   = bus.core_valid_out && pend_empty;
   assign rec_pop  = bus.rec_valid && bus.rec_ready;

   assign pend_in = '{tag: bus.iss_tag, mode: bus.iss_mode, op: bus.iss_op, ts: TS_BITS'(ts)};

   assign rec_in = '{
      tag:     pend_head.tag,
      mode:    pend_head.mode,
      op:      pend_head.op,
      result:  (pend_head.mode == MODE_FP16) ? {16'h0, bus.core_result16} : bus.core_result32,
      ovf:     bus.core_overflow,
      unf:     bus.core_underflow,
      latency: TS_BITS'(ts - TS_W'(pend_head.ts))
   };

   gf_sync_fifo #(.WIDTH($bits(pend_t)), .DEPTH(DEPTH)) u_pend (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (iss_fire),
      .pop   (res_fire),
      .din   (pend_in),
      .dout  (pend_head),
      .count (pend_count),
      .empty (pend_empty),
      .full  (pend_full)
   );

   gf_sync_fifo #(.WIDTH($bits(rec_t)), .DEPTH(DEPTH)) u_rec (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (res_fire),
      .pop   (rec_pop),
      .din   (rec_in),
      .dout  (rec_head),
      .count (rec_count),
      .empty (rec_empty),
      .full  (rec_full)
   );

   assign bus.rec_valid   = !rec_empty;
   assign bus.rec_tag     = TAG_W'(rec_head.tag);
   assign bus.rec_mode    = rec_head.mode;
   assign bus.rec_op      = rec_head.op;
   assign bus.rec_result  = rec_head.result;
   assign bus.rec_ovf     = rec_head.ovf;
   assign bus.rec_unf     = rec_head.unf;
   assign bus.rec_latency = TS_W'(rec_head.latency);

   // Saturating statistics and sticky flags; clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_count  <= '0;
         ovf_count   <= '0;
         unf_count   <= '0;
         orphan_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else if (clear_stats) begin
         done_count  <= '0;
         ovf_count   <= '0;
         unf_count   <= '0;
         orphan_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         if (res_fire && !(&done_count))                  done_count <= done_count + TS_W'(1);
         if (res_fire && rec_in.ovf && !(&ovf_count))     ovf_count  <= ovf_count + TS_W'(1);
         if (res_fire && rec_in.unf && !(&unf_count))     unf_count  <= unf_count + TS_W'(1);
         if (orphan)  orphan_err  <= 1'b1;
         if (overrun) overrun_err <= 1'b1;
      end
   end

   // The credit rule makes a push into a full queue unreachable.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(iss_fire && pend_full));
         assert (!(res_fire && rec_full));
      end
   end
endmodule

// File: tb/tb_gf_result_collector.sv
// Directed bench for gf_result_collector with a queue-level reference model.
module tb_gf_result_collector;
   import gf_collector_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear_stats = 1'b0;
   logic [15:0] done_count;
   logic [15:0] ovf_count;
   logic [15:0] unf_count;
   logic        orphan_err;
   logic        overrun_err;

   int errors = 0;
   int checks = 0;

   gf_result_collector_if #(.TAG_W(4), .TS_W(16)) bus ();

   gf_result_collector #(.DEPTH(DEPTH), .TAG_W(4), .TS_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .clear_stats (clear_stats),
      .done_count  (done_count),
      .ovf_count   (ovf_count),
      .unf_count   (unf_count),
      .orphan_err  (orphan_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queues of issued ops and produced records.
   pend_t       m_pend[$];
   rec_t        m_rec[$];
   pend_t       m_h;
   rec_t        m_r;
   logic [15:0] m_ts = '0;
   logic [15:0] m_done = '0;
   logic [15:0] m_ovf = '0;
   logic [15:0] m_unf = '0;
   logic        m_orph = 1'b0;
   logic        m_over = 1'b0;
   logic        m_ready_pre;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_pend.delete();
         m_rec.delete();
         m_ts = '0; m_done = '0; m_ovf = '0; m_unf = '0;
         m_orph = 1'b0; m_over = 1'b0;
      end else begin
         m_ready_pre = (m_pend.size() + m_rec.size()) < DEPTH;
         if (m_rec.size() > 0 && bus.rec_ready) void'(m_rec.pop_front());
         if (bus.core_valid_out) begin
            if (m_pend.size() > 0) begin
               m_h = m_pend.pop_front();
               m_r.tag     = m_h.tag;
               m_r.mode    = m_h.mode;
               m_r.op      = m_h.op;
               m_r.result  = m_h.mode ? {16'h0, bus.core_result16} : bus.core_result32;
               m_r.ovf     = bus.core_overflow;
               m_r.unf     = bus.core_underflow;
               m_r.latency = m_ts - m_h.ts;
               m_rec.push_back(m_r);
               if (m_done != 16'hFFFF) m_done++;
               if (m_r.ovf && m_ovf != 16'hFFFF) m_ovf++;
               if (m_r.unf && m_unf != 16'hFFFF) m_unf++;
            end else begin
               m_orph = 1'b1;
            end
         end
         if (bus.iss_valid) begin
            if (m_ready_pre) begin
               m_h.tag = bus.iss_tag; m_h.mode = bus.iss_mode; m_h.op = bus.iss_op; m_h.ts = m_ts;
               m_pend.push_back(m_h);
            end else begin
               m_over = 1'b1;
            end
         end
         if (clear_stats) begin
            m_done = '0; m_ovf = '0; m_unf = '0; m_orph = 1'b0; m_over = 1'b0;
         end
         m_ts++;
      end
      #1;
      chk("iss_ready", 32'(bus.iss_ready), 32'((m_pend.size() + m_rec.size()) < DEPTH));
      chk("rec_valid", 32'(bus.rec_valid), 32'(m_rec.size() > 0));
      if (m_rec.size() > 0) begin
         chk("rec_tag",     32'(bus.rec_tag),     32'(m_rec[0].tag));
         chk("rec_mode",    32'(bus.rec_mode),    32'(m_rec[0].mode));
         chk("rec_op",      32'(bus.rec_op),      32'(m_rec[0].op));
         chk("rec_result",  bus.rec_result,       m_rec[0].result);
         chk("rec_ovf",     32'(bus.rec_ovf),     32'(m_rec[0].ovf));
         chk("rec_unf",     32'(bus.rec_unf),     32'(m_rec[0].unf));
         chk("rec_latency", 32'(bus.rec_latency), 32'(m_rec[0].latency));
      end
      chk("done_count",  32'(done_count),  32'(m_done));
      chk("ovf_count",   32'(ovf_count),   32'(m_ovf));
      chk("unf_count",   32'(unf_count),   32'(m_unf));
      chk("orphan_err",  32'(orphan_err),  32'(m_orph));
      chk("overrun_err", 32'(overrun_err), 32'(m_over));
   end

   task automatic issue(input logic [3:0] tag, input logic mode, input logic [1:0] op);
      bus.iss_valid = 1'b1; bus.iss_tag = tag; bus.iss_mode = mode; bus.iss_op = op;
      @(negedge clk);
      bus.iss_valid = 1'b0;
   endtask

   task automatic result(input logic [31:0] r32, input logic [15:0] r16, input logic ovf, input logic unf);
      bus.core_valid_out = 1'b1; bus.core_result32 = r32; bus.core_result16 = r16;
      bus.core_overflow = ovf; bus.core_underflow = unf;
      @(negedge clk);
      bus.core_valid_out = 1'b0; bus.core_overflow = 1'b0; bus.core_underflow = 1'b0;
   endtask

   task automatic pop_one();
      bus.rec_ready = 1'b1;
      @(negedge clk);
      bus.rec_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      bus.iss_valid = 1'b0; bus.iss_mode = MODE_FP32; bus.iss_op = OP_ADD; bus.iss_tag = '0;
      bus.core_valid_out = 1'b0; bus.core_result32 = '0; bus.core_result16 = '0;
      bus.core_overflow = 1'b0; bus.core_underflow = 1'b0; bus.rec_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset iss_ready", 32'(bus.iss_ready), 32'd1);
      chk("reset rec_valid", 32'(bus.rec_valid), 32'd0);
      chk("reset done_count", 32'(done_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // FP16 MUL tag 3, result four cycles later
      issue(4'd3, MODE_FP16, OP_MUL);
      repeat (3) @(negedge clk);
      result(32'h0, 16'h4200, 1'b0, 1'b0);
      chk("t1 rec_valid", 32'(bus.rec_valid), 32'd1);
      chk("t1 rec_tag", 32'(bus.rec_tag), 32'd3);
      chk("t1 rec_mode", 32'(bus.rec_mode), 32'd1);
      chk("t1 rec_op", 32'(bus.rec_op), 32'd2);
      chk("t1 rec_result", bus.rec_result, 32'h0000_4200);
      chk("t1 rec_latency", 32'(bus.rec_latency), 32'd4);
      chk("t1 done_count", 32'(done_count), 32'd1);
      pop_one();

      // Two ops, in-order pairing
      issue(4'd1, MODE_FP32, OP_ADD);
      issue(4'd2, MODE_FP16, OP_ADD);
      result(32'h4000_0000, 16'h0, 1'b0, 1'b0);
      result(32'h0, 16'h4100, 1'b0, 1'b0);
      chk("t2 first tag", 32'(bus.rec_tag), 32'd1);
      chk("t2 first result", bus.rec_result, 32'h4000_0000);
      pop_one();
      chk("t2 second tag", 32'(bus.rec_tag), 32'd2);
      chk("t2 second result", bus.rec_result, 32'h0000_4100);
      pop_one();

      // Credit exhaustion with rec_ready held low
      for (int i = 4; i < 8; i++) issue(4'(i), MODE_FP32, OP_MUL);
      for (int i = 0; i < 4; i++) result(32'h3F80_0000 + 32'(i), 16'h0, 1'b0, 1'b0);
      chk("t3 iss_ready low", 32'(bus.iss_ready), 32'd0);
      issue(4'd8, MODE_FP32, OP_ADD);
      chk("t3 overrun_err", 32'(overrun_err), 32'd1);
      pop_one();
      chk("t3 iss_ready restored", 32'(bus.iss_ready), 32'd1);
      chk("t3 head after pop", 32'(bus.rec_tag), 32'd5);
      repeat (3) pop_one();

      // Orphan result, then clear
      result(32'hDEAD_BEEF, 16'h0, 1'b0, 1'b0);
      chk("t4 orphan_err", 32'(orphan_err), 32'd1);
      chk("t4 no record", 32'(bus.rec_valid), 32'd0);
      chk("t4 done_count", 32'(done_count), 32'd7);
      clear_stats = 1'b1; @(negedge clk); clear_stats = 1'b0;
      chk("t4 orphan cleared", 32'(orphan_err), 32'd0);
      chk("t4 overrun cleared", 32'(overrun_err), 32'd0);
      chk("t4 done cleared", 32'(done_count), 32'd0);

      // Overflow capture
      issue(4'd9, MODE_FP32, OP_MUL);
      result(32'h7F80_0000, 16'h0, 1'b1, 1'b0);
      chk("t5 rec_ovf", 32'(bus.rec_ovf), 32'd1);
      chk("t5 ovf_count", 32'(ovf_count), 32'd1);
      chk("t5 unf_count", 32'(unf_count), 32'd0);
      pop_one();

      // Clear beats a same-cycle increment
      issue(4'd10, MODE_FP16, OP_ADD);
      clear_stats = 1'b1;
      result(32'h0, 16'h3C00, 1'b0, 1'b1);
      clear_stats = 1'b0;
      chk("t6 clear wins done", 32'(done_count), 32'd0);
      chk("t6 clear wins unf", 32'(unf_count), 32'd0);
      pop_one();

      // Issue and result together with pending empty: orphan, op still queued
      bus.iss_valid = 1'b1; bus.iss_tag = 4'd11; bus.iss_mode = MODE_FP32; bus.iss_op = OP_ADD;
      result(32'h1111_1111, 16'h0, 1'b0, 1'b0);
      bus.iss_valid = 1'b0;
      chk("t7 orphan", 32'(orphan_err), 32'd1);
      chk("t7 no record", 32'(bus.rec_valid), 32'd0);
      result(32'h2222_2222, 16'h0, 1'b0, 1'b0);
      chk("t7 queued tag", 32'(bus.rec_tag), 32'd11);
      chk("t7 queued result", bus.rec_result, 32'h2222_2222);
      pop_one();

      // Reset with two ops pending
      issue(4'd12, MODE_FP32, OP_ADD);
      issue(4'd13, MODE_FP16, OP_MUL);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t8 iss_ready", 32'(bus.iss_ready), 32'd1);
      chk("t8 rec_valid", 32'(bus.rec_valid), 32'd0);
      chk("t8 orphan reset", 32'(orphan_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      result(32'h3333_3333, 16'h0, 1'b0, 1'b0);
      chk("t8 post-reset orphan", 32'(orphan_err), 32'd1);
      chk("t8 post-reset no record", 32'(bus.rec_valid), 32'd0);

      // Streaming run up to timestamp wrap, then saturation
      bus.rec_ready = 1'b1;
      bus.core_overflow = 1'b1; bus.core_underflow = 1'b1;
      bus.iss_valid = 1'b1; bus.iss_mode = MODE_FP32; bus.iss_op = OP_ADD;
      @(negedge clk);
      bus.core_valid_out = 1'b1;
      for (int i = 0; i < 70000 && m_ts != 16'hFFF0; i++) begin
         bus.iss_tag = 4'(i);
         bus.core_result32 = 32'(i);
         @(negedge clk);
      end
      bus.iss_valid = 1'b0;
      @(negedge clk);
      bus.core_valid_out = 1'b0; bus.core_overflow = 1'b0; bus.core_underflow = 1'b0;
      for (int i = 0; i < 100 && m_ts != 16'hFFFE; i++) @(negedge clk);
      chk("t9 issue ts", 32'(m_ts), 32'h0000_FFFE);
      issue(4'd14, MODE_FP16, OP_MUL);
      for (int i = 0; i < 100 && m_ts != 16'h0002; i++) @(negedge clk);
      result(32'h0, 16'h5555, 1'b1, 1'b1);
      chk("t9 wrap latency", 32'(bus.rec_latency), 32'd4);
      chk("t9 wrap tag", 32'(bus.rec_tag), 32'd14);
      bus.core_overflow = 1'b1; bus.core_underflow = 1'b1;
      bus.iss_valid = 1'b1;
      @(negedge clk);
      bus.core_valid_out = 1'b1;
      repeat (40) @(negedge clk);
      bus.iss_valid = 1'b0;
      @(negedge clk);
      bus.core_valid_out = 1'b0;
      @(negedge clk);
      chk("t10 done saturated", 32'(done_count), 32'h0000_FFFF);
      chk("t10 ovf saturated", 32'(ovf_count), 32'h0000_FFFF);
      chk("t10 unf saturated", 32'(unf_count), 32'h0000_FFFF);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
